biquad8_coeff_loader: RTL and testbench

Control-bus front end that feeds coefficients into the `biquad8_incremental` cascade. It holds a shadow bank of NCOEFF 18-bit coefficients written over a simple register bus. On a commit, it snapshots the bank and serially shifts the values into the downstream DSP B-register chain, last coefficient first. It then pulses the downstream update strobe so that every DSP switches coefficients in the same cycle.

---
 rtl/biquad8_coeff_loader.sv | 173 +++++++++++++++++
 tb/tb_biquad8_coeff_loader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/biquad8_coeff_loader.sv
// biquad8_coeff_loader
// Register-bus front end for the biquad8_incremental coefficient chain.
// A shadow bank is written over the bus. On commit, the shadow bank is
// snapshotted into a working bank. The working bank is then shifted serially
// into the cascade B1 chain, last coefficient first, and a single update
// strobe makes every DSP swap to the new coefficients together.
module biquad8_coeff_loader #(
    parameter int NCOEFF  = 2,
    parameter int ADRBITS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic               wr_i,
    input  logic [ADRBITS-1:0] adr_i,
    input  logic [17:0]        dat_i,
    output logic [17:0]        dat_o,
    output logic               ack_o,
    output logic [17:0]        coeff_dat_o,
    output logic               coeff_wr_o,
    output logic               coeff_update_o,
    output logic               busy_o
);

    localparam int IW = (NCOEFF > 1) ? $clog2(NCOEFF) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_UPD   = 2'd3;

    logic [1:0]    state_reg, state_next;
    logic [IW-1:0] idx_reg, idx_next;
    logic          pending_reg, pending_next;
    logic [17:0]   shadow_reg  [NCOEFF];
    logic [17:0]   working_reg [NCOEFF];
    logic [17:0]   dat_reg;
    logic          ack_reg;
    logic [17:0]   coeff_dat_reg;

    logic              ctl_hit;
    logic              bus_wr;
    logic              commit;
    logic              start;
    logic [NCOEFF-1:0] shadow_we;
    logic [17:0]       rd_val;
    logic [17:0]       load_val;

    assign bus_wr  = en_i & wr_i;
    assign ctl_hit = (adr_i == ADRBITS'(NCOEFF));
    assign commit  = bus_wr & ctl_hit & dat_i[0];

    // Per-register write-enable decode for the shadow bank.
    genvar gi;
    generate
        for (gi = 0; gi < NCOEFF; gi++) begin : g_we
            assign shadow_we[gi] = bus_wr && (adr_i == ADRBITS'(gi));
        end
    endgenerate

    // Next-state logic: a snapshot starts a load from IDLE; commits arriving while busy queue one load.
    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        pending_next = pending_reg;
        start        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (commit || pending_reg) begin
                    start        = 1'b1;
                    pending_next = 1'b0;
                    idx_next     = IW'(NCOEFF - 1);
                    state_next   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (idx_reg == '0) begin
                    state_next = ST_DRAIN;
                end else begin
                    idx_next = idx_reg - IW'(1);
                end
            end
            ST_DRAIN: state_next = ST_UPD;
            default:  state_next = ST_IDLE;
        endcase
        if (commit && (state_reg != ST_IDLE)) begin
            pending_next = 1'b1;
        end
    end

    // Bus read mux: shadow registers, status word, zero elsewhere.
    always_comb begin
        rd_val = '0;
        if (ctl_hit) begin
            rd_val = {16'd0, pending_reg, busy_o};
        end
        for (int i = 0; i < NCOEFF; i++) begin
            if (adr_i == ADRBITS'(i)) begin
                rd_val = shadow_reg[i];
            end
        end
    end

    // Select the working coefficient for the current shift step.
    always_comb begin
        load_val = '0;
        for (int i = 0; i < NCOEFF; i++) begin
            if (idx_reg == IW'(i)) begin
                load_val = working_reg[i];
            end
        end
    end

    // FSM, step counter and pending flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            idx_reg     <= '0;
            pending_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            pending_reg <= pending_next;
        end
    end

    // Shadow bank takes bus writes at any time; working bank is loaded only on a snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCOEFF; i++) begin
                shadow_reg[i]  <= '0;
                working_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCOEFF; i++) begin
                if (shadow_we[i]) begin
                    shadow_reg[i] <= dat_i;
                end
                if (start) begin
                    working_reg[i] <= shadow_reg[i];
                end
            end
        end
    end

    // Bus acknowledge and read data, one cycle after the strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_reg <= 1'b0;
            dat_reg <= '0;
        end else begin
            ack_reg <= en_i;
            dat_reg <= (en_i && !wr_i) ? rd_val : 18'd0;
        end
    end

    // Coefficient data trails the shift strobe by one cycle, matching the cascade's registered strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            coeff_dat_reg <= '0;
        end else if (state_reg == ST_LOAD) begin
            coeff_dat_reg <= load_val;
        end
    end

    assign dat_o          = dat_reg;
    assign ack_o          = ack_reg;
    assign coeff_dat_o    = coeff_dat_reg;
    assign coeff_wr_o     = (state_reg == ST_LOAD);
    assign coeff_update_o = (state_reg == ST_UPD);
    assign busy_o         = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_biquad8_coeff_loader.sv
// Self-checking bench for biquad8_coeff_loader (NCOEFF=2, ADRBITS=4).
// Bus reads and shifted coefficients are checked through scoreboard queues;
// the commit timing corner cases are checked cycle by cycle.
module tb_biquad8_coeff_loader;

    localparam int NC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_i = 1'b0;
    logic        wr_i = 1'b0;
    logic [3:0]  adr_i = '0;
    logic [17:0] dat_i = '0;
    logic [17:0] dat_o;
    logic        ack_o;
    logic [17:0] coeff_dat_o;
    logic        coeff_wr_o;
    logic        coeff_update_o;
    logic        busy_o;

    biquad8_coeff_loader #(.NCOEFF(NC), .ADRBITS(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .en_i           (en_i),
        .wr_i           (wr_i),
        .adr_i          (adr_i),
        .dat_i          (dat_i),
        .dat_o          (dat_o),
        .ack_o          (ack_o),
        .coeff_dat_o    (coeff_dat_o),
        .coeff_wr_o     (coeff_wr_o),
        .coeff_update_o (coeff_update_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_rd;
        logic [17:0] dat;
    } rd_t;

    typedef struct {
        logic        wr;
        logic [3:0]  adr;
        logic [17:0] dat;
        logic [17:0] exp;
    } vec_t;

    rd_t         rd_q[$];
    logic [17:0] coeff_q[$];
    int          errors = 0;
    int          checks = 0;
    int          upd_cnt = 0;
    int          wr_cnt = 0;
    logic        mon_prev_wr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_ctl(input string tag, input int o, input logic ew, input logic eu, input logic eb);
        chk($sformatf("%s_ctl_T+%0d", tag, o), {29'd0, coeff_wr_o, coeff_update_o, busy_o}, {29'd0, ew, eu, eb});
    endtask

    // One bus transaction; the expected ack/read data go to the scoreboard.
    task automatic bus(input logic w, input logic [3:0] a, input logic [17:0] d, input logic [17:0] e);
        rd_t r;
        en_i  = 1'b1;
        wr_i  = w;
        adr_i = a;
        dat_i = d;
        r.is_rd = !w;
        r.dat   = e;
        if (!rst) rd_q.push_back(r);
        @(negedge clk);
        #1;
        $display("bus %s adr=%h dat=%h exp=%h", w ? "wr" : "rd", a, d, e);
        en_i = 1'b0;
        wr_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic commit();
        bus(1'b1, 4'(NC), 18'h00001, 18'h0);
    endtask

    // Monitor: pops the scoreboards as the DUT produces acks and shifted data.
    initial begin
        rd_t r;
        forever begin
            @(negedge clk);
            chk("ack_present", {31'd0, ack_o}, {31'd0, (rd_q.size() > 0)});
            if (ack_o && rd_q.size() > 0) begin
                r = rd_q.pop_front();
                if (r.is_rd) chk("rd_data", {14'd0, dat_o}, {14'd0, r.dat});
            end
            if (mon_prev_wr && !rst) begin
                if (coeff_q.size() == 0) begin
                    chk("coeff_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("coeff_dat", {14'd0, coeff_dat_o}, {14'd0, coeff_q.pop_front()});
                end
            end
            mon_prev_wr = coeff_wr_o;
            if (coeff_update_o) upd_cnt++;
            if (coeff_wr_o) wr_cnt++;
        end
    end

    vec_t vecs[10];

    initial begin
        int u0, w0;

        vecs[0] = '{1'b1, 4'h0, 18'h00123, 18'h0};
        vecs[1] = '{1'b1, 4'h1, 18'h3FFFF, 18'h0};
        vecs[2] = '{1'b1, 4'hF, 18'h2AAAA, 18'h0};
        vecs[3] = '{1'b0, 4'h0, 18'h0,     18'h00123};
        vecs[4] = '{1'b0, 4'h1, 18'h0,     18'h3FFFF};
        vecs[5] = '{1'b0, 4'hF, 18'h0,     18'h0};
        vecs[6] = '{1'b0, 4'h5, 18'h0,     18'h0};
        vecs[7] = '{1'b1, 4'h2, 18'h3FFFE, 18'h0};
        vecs[8] = '{1'b0, 4'h2, 18'h0,     18'h0};
        vecs[9] = '{1'b0, 4'h3, 18'h0,     18'h0};

        // Reset with every input active: nothing may come out.
        rst = 1'b1; en_i = 1'b1; wr_i = 1'b1; adr_i = 4'(NC); dat_i = 18'h3FFFF;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk($sformatf("reset_outputs_%0d", c),
                {dat_o, ack_o, coeff_wr_o, coeff_update_o, busy_o, 10'd0}, 32'd0);
            chk($sformatf("reset_coeff_dat_%0d", c), {14'd0, coeff_dat_o}, 32'd0);
        end
        #1;
        rst = 1'b0; en_i = 1'b0; wr_i = 1'b0;
        bus(1'b0, 4'(NC), 18'h0, 18'h0);
        bus(1'b0, 4'h0, 18'h0, 18'h0);

        // Table-driven register map vectors.
        w0 = wr_cnt;
        for (int i = 0; i < 10; i++) begin
            bus(vecs[i].wr, vecs[i].adr, vecs[i].dat, vecs[i].exp);
        end
        idle(2);
        chk("no_commit_on_bit0_clear", wr_cnt - w0, 0);
        chk("idle_busy", {31'd0, busy_o}, 32'd0);

        // Commit timing with adr0=0x00123, adr1=0x3FFFF.
        u0 = upd_cnt;
        coeff_q.push_back(18'h3FFFF);
        coeff_q.push_back(18'h00123);
        commit();
        for (int o = 1; o <= 7; o++) begin
            chk_ctl("commit", o, (o >= 1 && o <= NC), (o == NC + 2), (o >= 1 && o <= NC + 2));
            if (o == 2) chk("dat_T+2", {14'd0, coeff_dat_o}, 32'h3FFFF);
            if (o == 3) chk("dat_T+3", {14'd0, coeff_dat_o}, 32'h00123);
            if (o < 7) idle(1);
        end
        chk("commit_upd_count", upd_cnt - u0, 1);

        // Shadow write during LOAD only affects the next commit.
        u0 = upd_cnt;
        coeff_q.push_back(18'h3FFFF);
        coeff_q.push_back(18'h00123);
        commit();
        bus(1'b1, 4'h0, 18'h00555, 18'h0);
        idle(5);
        coeff_q.push_back(18'h3FFFF);
        coeff_q.push_back(18'h00555);
        commit();
        idle(6);
        chk("midload_upd_count", upd_cnt - u0, 2);

        // Commits at T, T+1, T+2: one queued load starting at T+6.
        u0 = upd_cnt;
        w0 = wr_cnt;
        coeff_q.push_back(18'h3FFFF);
        coeff_q.push_back(18'h00555);
        coeff_q.push_back(18'h3FFFF);
        coeff_q.push_back(18'h00555);
        commit();
        chk_ctl("b2b", 1, 1'b1, 1'b0, 1'b1);
        commit();
        chk_ctl("b2b", 2, 1'b1, 1'b0, 1'b1);
        commit();
        chk_ctl("b2b", 3, 1'b0, 1'b0, 1'b1);
        bus(1'b0, 4'(NC), 18'h0, 18'h00003);
        for (int o = 4; o <= 11; o++) begin
            chk_ctl("b2b", o, (o == 6 || o == 7), (o == 4 || o == 9), (o != 5 && o <= 9));
            idle(1);
        end
        chk("b2b_upd_count", upd_cnt - u0, 2);
        chk("b2b_wr_count", wr_cnt - w0, 2 * NC);

        // Reset during LOAD aborts the load without an update pulse.
        bus(1'b1, 4'h0, 18'h11111, 18'h0);
        bus(1'b1, 4'h1, 18'h22222, 18'h0);
        u0 = upd_cnt;
        coeff_q.push_back(18'h22222);
        commit();
        idle(1);
        rst = 1'b1;
        @(negedge clk);
        chk_ctl("abort", 3, 1'b0, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        idle(8);
        chk("abort_no_update", upd_cnt - u0, 0);
        bus(1'b0, 4'h0, 18'h0, 18'h0);
        bus(1'b0, 4'h1, 18'h0, 18'h0);
        bus(1'b0, 4'(NC), 18'h0, 18'h0);

        idle(2);
        chk("rd_queue_drained", rd_q.size(), 0);
        chk("coeff_queue_drained", coeff_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
